// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the multi-port register file.
package regfile_pkg;

    localparam int unsigned DEF_DATA_W = 16;
    localparam int unsigned DEF_ADDR_W = 4;
    localparam int unsigned DEF_NUM_RD = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } sweep_state_t;

endpackage

// File: rtl/regfile_sweep_ctrl.sv
// Zero-sweep sequencer: walks indices 1..NUM_REGS-1, one register per cycle,
// pulsing clr_done on the final index.
module regfile_sweep_ctrl
    import regfile_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              clr_done,
    output logic [ADDR_W-1:0] sweep_idx
);

    sweep_state_t      state, state_nxt;
    logic [ADDR_W-1:0] cnt, cnt_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Register 0 is hard-wired to zero, so the sweep starts at index 1.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (clr_req) begin
                    state_nxt = SWEEP;
                    cnt_nxt   = ADDR_W'(1);
                end
            end
            SWEEP: begin
                cnt_nxt = cnt + ADDR_W'(1);
                if (cnt == '1) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            end
        endcase
    end

    always_comb begin
        clr_busy  = (state == SWEEP);
        clr_done  = (state == SWEEP) && (cnt == '1);
        sweep_idx = cnt;
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with byte-lane writes and a zero sweep.
// Define REGFILE_MP_BYPASS_EN to forward same-cycle write data to the read ports.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned NUM_RD = DEF_NUM_RD
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [DATA_W/8-1:0]      wbe,
    output logic                     wr_ok,
    input  logic                     clr_req,
    output logic                     clr_busy,
    output logic                     clr_done
);

    localparam int unsigned NUM_REGS = 2 ** ADDR_W;
    localparam int unsigned LANES    = DATA_W / 8;

`ifdef REGFILE_MP_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [ADDR_W-1:0] sweep_idx;
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rv;

    function automatic logic [DATA_W-1:0] merge_lanes(
        input logic [DATA_W-1:0] cur,
        input logic [DATA_W-1:0] upd,
        input logic [LANES-1:0]  be
    );
        logic [DATA_W-1:0] res;
        res = cur;
        for (int unsigned b = 0; b < LANES; b++) begin
            if (be[b]) res[b*8 +: 8] = upd[b*8 +: 8];
        end
        return res;
    endfunction

    regfile_sweep_ctrl #(
        .ADDR_W (ADDR_W)
    ) u_sweep (
        .clk       (clk),
        .rst       (rst),
        .clr_req   (clr_req),
        .clr_busy  (clr_busy),
        .clr_done  (clr_done),
        .sweep_idx (sweep_idx)
    );

    always_comb begin
        wr_ok = we & ~clr_busy & ~clr_req & (waddr != '0) & (|wbe);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[ADDR_W'(i)] <= '0;
            end
        end else if (clr_busy) begin
            regs[sweep_idx] <= '0;
        end else if (wr_ok) begin
            regs[waddr] <= merge_lanes(regs[waddr], wdata, wbe);
        end
    end

    // Address 0 is forced to zero after the bypass merge so r0 never leaks data.
    always_comb begin
        rd_data = '0;
        ra      = '0;
        rv      = '0;
        for (int unsigned k = 0; k < NUM_RD; k++) begin
            ra = rd_addr[k*ADDR_W +: ADDR_W];
            rv = regs[ra];
            if (BYPASS && wr_ok && (ra == waddr)) rv = merge_lanes(rv, wdata, wbe);
            if (ra == '0) rv = '0;
            rd_data[k*DATA_W +: DATA_W] = rv;
        end
    end

endmodule
